// File: rtl/packet_rr_arbiter_if.sv
// Per-channel AXI-Stream style inputs and the single muxed output of the packet arbiter.
// 'slave' is the arbiter's view; 'master' is the queues/routing-stage view.
interface packet_rr_arbiter_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int CHANNEL_NUMBER = 5
);
    logic [CHANNEL_NUMBER-1:0]            in_tvalid;
    logic [CHANNEL_NUMBER*DATA_WIDTH-1:0] in_tdata;
    logic [CHANNEL_NUMBER-1:0]            in_tlast;
    logic [CHANNEL_NUMBER-1:0]            in_tready;
    logic                                 out_tvalid;
    logic [DATA_WIDTH-1:0]                out_tdata;
    logic                                 out_tlast;
    logic                                 out_tready;

    modport slave (
        input  in_tvalid, in_tdata, in_tlast, out_tready,
        output in_tready, out_tvalid, out_tdata, out_tlast
    );

    modport master (
        output in_tvalid, in_tdata, in_tlast, out_tready,
        input  in_tready, out_tvalid, out_tdata, out_tlast
    );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Packet-level round-robin arbiter: locks one input channel per packet onto the
// crossbar path and exposes the header's target X/Y to the routing stage.
module packet_rr_arbiter #(
    parameter int  DATA_WIDTH       = 32,
    parameter int  CHANNEL_NUMBER   = 5,
    parameter int  MAX_ROUTERS_X    = 4,
    parameter int  MAX_ROUTERS_Y    = 4,
    parameter int  MAX_PACKET_FLITS = 16,
    localparam int TX_W  = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1,
    localparam int TY_W  = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1,
    localparam int CNT_W = $clog2(MAX_PACKET_FLITS + 1),
    localparam int IDX_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1
) (
    input  logic              clk,
    input  logic              rst,
    packet_rr_arbiter_if.slave bus,
    output logic [TX_W-1:0]   target_x,
    output logic [TY_W-1:0]   target_y,
    output logic              grant_valid,
    output logic [IDX_W-1:0]  grant_idx,
    output logic [CNT_W-1:0]  flit_cnt,
    output logic              len_err
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] grant_idx_q;
    logic             grant_valid_q;
    logic [TX_W-1:0]  target_x_q;
    logic [TY_W-1:0]  target_y_q;
    logic [CNT_W-1:0] flit_cnt_q;
    logic [CNT_W-1:0] flit_cnt_d;
    logic             len_err_q;

    logic [DATA_WIDTH-1:0] ch_data [CHANNEL_NUMBER];
    logic                  req_found;
    logic [IDX_W-1:0]      req_idx;
    logic                  fwd_en;
    logic                  hs;
    logic                  at_limit;
    logic                  release_pkt;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= CHANNEL_NUMBER) sum = sum - CHANNEL_NUMBER;
        return IDX_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            ch_data[i] = bus.in_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // First valid channel at or after rr_ptr, wrapping modulo CHANNEL_NUMBER.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; otherwise a latch is inferred.
        req_found = 1'b0;
        req_idx   = '0;
        for (int k = 0; k < CHANNEL_NUMBER; k++) begin
            if (!req_found && bus.in_tvalid[wrap_add(rr_ptr_q, k)]) begin
                req_found = 1'b1;
                req_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Forwarding is blanked during reset so no flit is consumed in that cycle.
    assign fwd_en = (state_q == LOCKED) && !rst;

    always_comb begin
        bus.in_tready  = '0;
        bus.out_tvalid = 1'b0;
        bus.out_tdata  = '0;
        bus.out_tlast  = 1'b0;
        if (fwd_en) begin
            bus.out_tvalid             = bus.in_tvalid[grant_idx_q];
            bus.out_tdata              = ch_data[grant_idx_q];
            bus.out_tlast              = bus.in_tlast[grant_idx_q];
            bus.in_tready[grant_idx_q] = bus.out_tready;
        end
    end

    assign hs          = bus.out_tvalid & bus.out_tready;
    assign at_limit    = (flit_cnt_q == CNT_W'(MAX_PACKET_FLITS - 1));
    assign release_pkt = hs & (bus.out_tlast | at_limit);
    assign flit_cnt_d  = (&flit_cnt_q) ? flit_cnt_q : flit_cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            target_x_q    <= '0;
            target_y_q    <= '0;
            flit_cnt_q    <= '0;
            len_err_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every register sees pre-edge values of the others.
            case (state_q)
                IDLE: begin
                    if (req_found) begin
                        state_q       <= LOCKED;
                        grant_idx_q   <= req_idx;
                        grant_valid_q <= 1'b1;
                        target_x_q    <= ch_data[req_idx][TX_W-1:0];
                        target_y_q    <= ch_data[req_idx][TX_W +: TY_W];
                        flit_cnt_q    <= '0;
                    end
                end
                LOCKED: begin
                    if (hs) flit_cnt_q <= flit_cnt_d;
                    if (release_pkt) begin
                        state_q       <= IDLE;
                        grant_valid_q <= 1'b0;
                        rr_ptr_q      <= wrap_add(grant_idx_q, 1);
                        if (!bus.out_tlast) len_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign target_x    = target_x_q;
    assign target_y    = target_y_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign flit_cnt    = flit_cnt_q;
    assign len_err     = len_err_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed bench for packet_rr_arbiter: per-channel source queues feed the DUT and a
// scoreboard holds the flits in the order the round-robin policy must deliver them.
module tb_packet_rr_arbiter;
    localparam int DW    = 32;
    localparam int CN    = 5;
    localparam int MPF   = 4;
    localparam int TX_W  = 2;
    localparam int TY_W  = 2;
    localparam int IDX_W = 3;
    localparam int CNT_W = 3;

    typedef logic [DW:0] flit_t;  // {tlast, tdata}

    logic clk;
    logic rst;
    logic rst_req;
    logic ready_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    packet_rr_arbiter_if #(.DATA_WIDTH(DW), .CHANNEL_NUMBER(CN)) bus ();

    logic [TX_W-1:0]  target_x;
    logic [TY_W-1:0]  target_y;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [CNT_W-1:0] flit_cnt;
    logic             len_err;

    packet_rr_arbiter #(
        .DATA_WIDTH(DW), .CHANNEL_NUMBER(CN), .MAX_ROUTERS_X(4),
        .MAX_ROUTERS_Y(4), .MAX_PACKET_FLITS(MPF)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .target_x(target_x), .target_y(target_y), .grant_valid(grant_valid),
        .grant_idx(grant_idx), .flit_cnt(flit_cnt), .len_err(len_err)
    );

    flit_t   src_q [CN][$];
    flit_t   sb_q [$];
    int      glog [$];
    int      gaplog [$];
    int      exp_g [$];
    int      gap_cnt;
    logic    prev_gv;
    logic [CN-1:0] hs_ch;
    int      n_tests;
    int      n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input int ch);
        return 32'h5000_0000 | (32'(ch) << 8) | 32'(ch & 15);
    endfunction

    function automatic flit_t flit(input int ch, input int n, input int total, input logic [DW-1:0] h);
        logic [DW-1:0] d;
        d = (n == 0) ? h : {8'hA0, 8'(ch), 16'(n)};
        return {(n == total - 1), d};
    endfunction

    task automatic src_pkt(input int ch, input int total, input logic [DW-1:0] h);
        for (int n = 0; n < total; n++) src_q[ch].push_back(flit(ch, n, total, h));
    endtask

    task automatic exp_flits(input int ch, input int from, input int to, input int total, input logic [DW-1:0] h);
        for (int n = from; n < to; n++) sb_q.push_back(flit(ch, n, total, h));
    endtask

    task automatic drive();
        for (int i = 0; i < CN; i++) begin
            if (src_q[i].size() > 0) begin
                bus.in_tvalid[i]           = 1'b1;
                bus.in_tdata[i*DW +: DW]   = src_q[i][0][DW-1:0];
                bus.in_tlast[i]            = src_q[i][0][DW];
            end else begin
                bus.in_tvalid[i]           = 1'b0;
                bus.in_tdata[i*DW +: DW]   = '0;
                bus.in_tlast[i]            = 1'b0;
            end
        end
    endtask

    // One clock: retire last cycle's handshakes, drive new inputs after the edge,
    // then sample outputs on the falling edge and score any transferred flit.
    task automatic tick();
        flit_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < CN; i++) begin
            if (hs_ch[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        drive();
        bus.out_tready = ready_req;
        rst = rst_req;
        @(negedge clk);
        hs_ch = bus.in_tvalid & bus.in_tready;
        if (bus.out_tvalid && bus.out_tready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_flit", {bus.out_tlast, bus.out_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("flit", {bus.out_tlast, bus.out_tdata}, e);
            end
        end
        if (!rst) begin
            if (grant_valid && !prev_gv) begin
                glog.push_back(int'(grant_idx));
                gaplog.push_back(gap_cnt);
                gap_cnt = 0;
            end else if (!grant_valid) begin
                gap_cnt++;
            end
            prev_gv = grant_valid;
        end else begin
            prev_gv = 1'b0;
        end
    endtask

    function automatic bit busy();
        bit b;
        b = grant_valid || (sb_q.size() > 0);
        for (int i = 0; i < CN; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 64'(busy()), 64'd0);
    endtask

    task automatic clear_logs();
        glog.delete();
        gaplog.delete();
        exp_g.delete();
        gap_cnt = 0;
    endtask

    task automatic flush_sources();
        for (int i = 0; i < CN; i++) src_q[i].delete();
        sb_q.delete();
        hs_ch = '0;
    endtask

    task automatic apply_reset();
        rst_req = 1'b1;
        tick();
        flush_sources();
        rst_req = 1'b0;
        tick();
    endtask

    task automatic exp_grants(input int g0 = -1, input int g1 = -1, input int g2 = -1,
                              input int g3 = -1, input int g4 = -1, input int g5 = -1);
        int g [6];
        g = '{g0, g1, g2, g3, g4, g5};
        exp_g.delete();
        for (int i = 0; i < 6; i++) if (g[i] >= 0) exp_g.push_back(g[i]);
    endtask

    task automatic check_glog(input string tag);
        check({tag, "_ngrants"}, 64'(glog.size()), 64'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++) begin
            check($sformatf("%s_grant%0d", tag, i), 64'((i < glog.size()) ? glog[i] : -1), 64'(exp_g[i]));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        gap_cnt = 0;
        prev_gv = 1'b0;
        hs_ch   = '0;
        rst     = 1'b1;
        rst_req = 1'b1;
        ready_req      = 1'b1;
        bus.in_tvalid  = '0;
        bus.in_tdata   = '0;
        bus.in_tlast   = '0;
        bus.out_tready = 1'b1;

        // Reset state
        tick();
        tick();
        rst_req = 1'b0;
        tick();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_in_tready", bus.in_tready, 0);
        check("rst_out_tvalid", bus.out_tvalid, 0);
        check("rst_out_tdata", bus.out_tdata, 0);
        check("rst_target_xy", {target_y, target_x}, 0);
        check("rst_flit_cnt", flit_cnt, 0);
        check("rst_len_err", len_err, 0);

        // Single 3-flit packet on ch2, header 0x9 -> x=1, y=2
        clear_logs();
        src_pkt(2, 3, 32'h0000_0009);
        exp_flits(2, 0, 3, 3, 32'h0000_0009);
        tick();
        check("t1_arb_gap_gv", grant_valid, 0);
        check("t1_arb_gap_ready", bus.in_tready, 0);
        tick();
        check("t1_grant_valid", grant_valid, 1);
        check("t1_grant_idx", grant_idx, 2);
        check("t1_target_x", target_x, 1);
        check("t1_target_y", target_y, 2);
        check("t1_cnt0", flit_cnt, 0);
        check("t1_ready", bus.in_tready, 5'b00100);
        tick();
        check("t1_cnt1", flit_cnt, 1);
        tick();
        check("t1_cnt2", flit_cnt, 2);
        tick();
        check("t1_released", grant_valid, 0);
        check("t1_cnt3", flit_cnt, 3);
        check("t1_sb_empty", 64'(sb_q.size()), 0);

        // rr_ptr must now be 3: ch3 wins over ch2
        clear_logs();
        src_pkt(2, 1, hdr(2));
        src_pkt(3, 1, hdr(3));
        exp_flits(3, 0, 1, 1, hdr(3));
        exp_flits(2, 0, 1, 1, hdr(2));
        tick();
        check("t1b_idle_out_tvalid", bus.out_tvalid, 0);
        check("t1b_idle_out_tdata", bus.out_tdata, 0);
        check("t1b_idle_out_tlast", bus.out_tlast, 0);
        wait_idle("t1b", 40);
        exp_grants(3, 2);
        check_glog("t1b");

        // Round-robin fairness from rr_ptr=0 with ch0, ch1, ch4 saturated
        apply_reset();
        clear_logs();
        for (int r = 0; r < 2; r++) begin
            src_pkt(0, 2, hdr(0));
            src_pkt(1, 2, hdr(1));
            src_pkt(4, 2, hdr(4));
            exp_flits(0, 0, 2, 2, hdr(0));
            exp_flits(1, 0, 2, 2, hdr(1));
            exp_flits(4, 0, 2, 2, hdr(4));
        end
        wait_idle("rr", 100);
        exp_grants(0, 1, 4, 0, 1, 4);
        check_glog("rr");
        for (int i = 0; i < gaplog.size(); i++) check($sformatf("rr_gap%0d", i), 64'(gaplog[i]), 1);

        // Backpressure on a 4-flit ch3 packet while ch0/ch1 wait
        clear_logs();
        src_pkt(3, 4, hdr(3));
        exp_flits(3, 0, 4, 4, hdr(3));
        tick();
        src_pkt(0, 1, hdr(0));
        src_pkt(1, 1, hdr(1));
        exp_flits(0, 0, 1, 1, hdr(0));
        exp_flits(1, 0, 1, 1, hdr(1));
        tick();
        check("bp_grant_idx", grant_idx, 3);
        check("bp_c1_ready", bus.in_tready, 5'b01000);
        ready_req = 1'b0;
        tick();
        check("bp_c2_ready", bus.in_tready, 5'b00000);
        check("bp_c2_valid_held", bus.out_tvalid, 1);
        check("bp_c2_cnt", flit_cnt, 1);
        tick();
        check("bp_c3_ready", bus.in_tready, 5'b00000);
        check("bp_c3_cnt", flit_cnt, 1);
        ready_req = 1'b1;
        tick();
        check("bp_c4_ready", bus.in_tready, 5'b01000);
        tick();
        tick();
        check("bp_c6_cnt", flit_cnt, 3);
        tick();
        check("bp_exact_max_released", grant_valid, 0);
        check("bp_exact_max_cnt", flit_cnt, 4);
        check("bp_exact_max_no_err", len_err, 0);
        wait_idle("bp", 40);
        exp_grants(3, 0, 1);
        check_glog("bp");

        // Over-length: 6 flits on ch1 with MAX_PACKET_FLITS=4, rr_ptr=2
        clear_logs();
        src_pkt(1, 6, hdr(1));
        exp_flits(1, 0, 4, 6, hdr(1));
        tick();
        src_pkt(2, 2, hdr(2));
        src_pkt(0, 2, hdr(0));
        exp_flits(2, 0, 2, 2, hdr(2));
        exp_flits(0, 0, 2, 2, hdr(0));
        exp_flits(1, 4, 6, 6, hdr(1));
        tick();
        tick();
        tick();
        tick();
        check("ol_before_gv", grant_valid, 1);
        check("ol_before_cnt", flit_cnt, 3);
        check("ol_before_err", len_err, 0);
        tick();
        check("ol_forced_release", grant_valid, 0);
        check("ol_err_set", len_err, 1);
        check("ol_cnt", flit_cnt, 4);
        check("ol_release_ready", bus.in_tready, 0);
        wait_idle("ol", 100);
        check("ol_err_sticky", len_err, 1);
        exp_grants(1, 2, 0, 1);
        check_glog("ol");

        // Reset after flit 2 of a 4-flit ch0 packet (rr_ptr=2 beforehand)
        clear_logs();
        src_pkt(0, 4, hdr(0));
        exp_flits(0, 0, 4, 4, hdr(0));
        tick();
        tick();
        tick();
        rst_req = 1'b1;
        tick();
        check("rm_rst_cycle_ready", bus.in_tready, 0);
        check("rm_rst_cycle_out_tvalid", bus.out_tvalid, 0);
        check("rm_rst_cycle_cnt", flit_cnt, 2);
        flush_sources();
        rst_req = 1'b0;
        tick();
        check("rm_gv", grant_valid, 0);
        check("rm_ready", bus.in_tready, 0);
        check("rm_len_err", len_err, 0);
        check("rm_cnt", flit_cnt, 0);
        check("rm_grant_idx", grant_idx, 0);
        clear_logs();
        src_pkt(3, 1, hdr(3));
        src_pkt(1, 1, hdr(1));
        exp_flits(1, 0, 1, 1, hdr(1));
        exp_flits(3, 0, 1, 1, hdr(3));
        wait_idle("rm", 40);
        exp_grants(1, 3);
        check_glog("rm");

        // Wrap-around: rr_ptr=4, ch4 then ch0
        clear_logs();
        src_pkt(0, 2, hdr(0));
        src_pkt(4, 2, hdr(4));
        exp_flits(4, 0, 2, 2, hdr(4));
        exp_flits(0, 0, 2, 2, hdr(0));
        wait_idle("wrap", 40);
        exp_grants(4, 0);
        check_glog("wrap");
        check("wrap_target_x", target_x, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
